// File: rtl/lerp_pkg.sv
// Shared types and fixed-point helpers for the lerp2 sweep initiator.
package lerp_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} sweep_state_t;

  localparam int LP_WIDTH = 32;
  localparam int LP_FBITS = 16;
  localparam int LP_CNT_W = 16;

  localparam logic [LP_WIDTH-1:0] ONE = LP_WIDTH'(1) << LP_FBITS;

  // Integer grid index -> unsigned fixed point {idx, FBITS'b0}.
  function automatic logic [LP_WIDTH-1:0] to_fix(input logic [LP_CNT_W-1:0] idx);
    return LP_WIDTH'(idx) << LP_FBITS;
  endfunction

endpackage

// File: rtl/lerp2_sweep_addr.sv
// Raster (xi,yi) counter over an nx*ny cell; x runs fastest.
module lerp2_sweep_addr
  import lerp_pkg::*;
#(
  parameter int CNT_W = LP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [CNT_W-1:0] nx,
  input  logic [CNT_W-1:0] ny,
  output logic [CNT_W-1:0] xi,
  output logic [CNT_W-1:0] yi,
  output logic             is_last
);

  logic [CNT_W-1:0] xi_q, xi_d;
  logic [CNT_W-1:0] yi_q, yi_d;
  logic             x_end, y_end;

  assign x_end = (xi_q == nx - CNT_W'(1));
  assign y_end = (yi_q == ny - CNT_W'(1));

  always_comb begin
    xi_d = xi_q;
    yi_d = yi_q;
    if (clr) begin
      xi_d = '0;
      yi_d = '0;
    end else if (adv) begin
      if (x_end) begin
        xi_d = '0;
        yi_d = yi_q + CNT_W'(1);
      end else begin
        xi_d = xi_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xi_q <= '0;
      yi_q <= '0;
    end else begin
      xi_q <= xi_d;
      yi_q <= yi_d;
    end
  end

  assign xi      = xi_q;
  assign yi      = yi_q;
  assign is_last = x_end & y_end;

endmodule

// File: rtl/lerp2_sweep.sv
// lerp2 initiator: walks every grid point of one cell, one engine call per point,
// one result in flight, results streamed out on a valid/ready port.
module lerp2_sweep
  import lerp_pkg::*;
#(
  parameter int WIDTH = LP_WIDTH,
  parameter int FBITS = LP_FBITS,
  parameter int CNT_W = LP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_p0,
  input  logic [WIDTH-1:0] cmd_p1,
  input  logic [WIDTH-1:0] cmd_p2,
  input  logic [WIDTH-1:0] cmd_p3,
  input  logic [WIDTH-1:0] cmd_X,
  input  logic [WIDTH-1:0] cmd_Y,
  output logic [WIDTH-1:0] eng_p0,
  output logic [WIDTH-1:0] eng_p1,
  output logic [WIDTH-1:0] eng_p2,
  output logic [WIDTH-1:0] eng_p3,
  output logic [WIDTH-1:0] eng_x,
  output logic [WIDTH-1:0] eng_y,
  output logic [WIDTH-1:0] eng_X,
  output logic [WIDTH-1:0] eng_Y,
  output logic             eng_start,
  input  logic [WIDTH-1:0] eng_val,
  input  logic             eng_done,
  input  logic             eng_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [CNT_W-1:0] out_xi,
  output logic [CNT_W-1:0] out_yi,
  output logic             out_last,
  output logic             out_error,
  output logic             busy
);

  sweep_state_t state_q, state_d;

  logic [WIDTH-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d;
  logic [WIDTH-1:0] oval_q, oval_d;
  logic [CNT_W-1:0] oxi_q, oxi_d, oyi_q, oyi_d;
  logic             olast_q, olast_d;
  logic             oerr_q, oerr_d;

  logic             addr_clr, addr_adv, addr_last;
  logic [CNT_W-1:0] xi, yi;
  logic [CNT_W-1:0] cmd_nx, cmd_ny, nx, ny;

  // Integer part of the size, clipped to the counter width (negative sizes become large counts).
  assign cmd_nx = cmd_X[FBITS +: CNT_W];
  assign cmd_ny = cmd_Y[FBITS +: CNT_W];
  assign nx     = xs_q[FBITS +: CNT_W];
  assign ny     = ys_q[FBITS +: CNT_W];

  lerp2_sweep_addr #(.CNT_W(CNT_W)) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (addr_clr),
    .adv     (addr_adv),
    .nx      (nx),
    .ny      (ny),
    .xi      (xi),
    .yi      (yi),
    .is_last (addr_last)
  );

  always_comb begin
    state_d  = state_q;
    p0_d     = p0_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    p3_d     = p3_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    oval_d   = oval_q;
    oxi_d    = oxi_q;
    oyi_d    = oyi_q;
    olast_d  = olast_q;
    oerr_d   = oerr_q;
    addr_clr = 1'b0;
    addr_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          p0_d     = cmd_p0;
          p1_d     = cmd_p1;
          p2_d     = cmd_p2;
          p3_d     = cmd_p3;
          xs_d     = cmd_X;
          ys_d     = cmd_Y;
          addr_clr = 1'b1;
          if (cmd_nx == '0 || cmd_ny == '0) begin
            // Empty cell: answer with a single flagged sample, engine never called.
            oval_d  = '0;
            oxi_d   = '0;
            oyi_d   = '0;
            olast_d = 1'b1;
            oerr_d  = 1'b1;
            state_d = EMIT;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Only looked at from WAIT, so a done left over from a prior call during ISSUE is ignored.
        if (eng_done) begin
          oval_d  = eng_val;
          oxi_d   = xi;
          oyi_d   = yi;
          oerr_d  = eng_error;
          olast_d = eng_error | addr_last;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (olast_q) begin
            state_d = IDLE;
          end else begin
            addr_adv = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      oval_q  <= '0;
      oxi_q   <= '0;
      oyi_q   <= '0;
      olast_q <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      oval_q  <= oval_d;
      oxi_q   <= oxi_d;
      oyi_q   <= oyi_d;
      olast_q <= olast_d;
      oerr_q  <= oerr_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign eng_start = (state_q == ISSUE);
  assign out_valid = (state_q == EMIT);

  assign eng_p0 = p0_q;
  assign eng_p1 = p1_q;
  assign eng_p2 = p2_q;
  assign eng_p3 = p3_q;
  assign eng_X  = xs_q;
  assign eng_Y  = ys_q;
  assign eng_x  = WIDTH'(xi) << FBITS;
  assign eng_y  = WIDTH'(yi) << FBITS;

  assign out_val   = oval_q;
  assign out_xi    = oxi_q;
  assign out_yi    = oyi_q;
  assign out_last  = olast_q;
  assign out_error = oerr_q;

endmodule

// File: tb/tb_lerp2_sweep.sv
// Directed bench for lerp2_sweep with a behavioural lerp2 engine (exact math, random latency).
module tb_lerp2_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_p0, cmd_p1, cmd_p2, cmd_p3, cmd_X, cmd_Y;
  logic [31:0] eng_p0, eng_p1, eng_p2, eng_p3, eng_x, eng_y, eng_X, eng_Y;
  logic        eng_start;
  logic [31:0] eng_val;
  logic        eng_done, eng_error;
  logic        out_valid, out_ready;
  logic [31:0] out_val;
  logic [15:0] out_xi, out_yi;
  logic        out_last, out_error, busy;

  int n_cmp = 0, n_bad = 0;
  int start_cnt = 0, call_no = 0, err_call = 0, min_lat = 1;

  always #5 clk = ~clk;

  lerp2_sweep dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_p0(cmd_p0), .cmd_p1(cmd_p1), .cmd_p2(cmd_p2), .cmd_p3(cmd_p3),
    .cmd_X(cmd_X), .cmd_Y(cmd_Y),
    .eng_p0(eng_p0), .eng_p1(eng_p1), .eng_p2(eng_p2), .eng_p3(eng_p3),
    .eng_x(eng_x), .eng_y(eng_y), .eng_X(eng_X), .eng_Y(eng_Y),
    .eng_start(eng_start), .eng_val(eng_val), .eng_done(eng_done), .eng_error(eng_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_xi(out_xi), .out_yi(out_yi), .out_last(out_last), .out_error(out_error),
    .busy(busy)
  );

  function automatic logic [31:0] lerp_model(input logic [31:0] a0, a1, a2, a3, x, y, xs, ys);
    longint p0, p1, p2, p3, fx, fy, lx, ly, num;
    p0 = longint'($signed(a0)); p1 = longint'($signed(a1));
    p2 = longint'($signed(a2)); p3 = longint'($signed(a3));
    fx = longint'(x); fy = longint'(y); lx = longint'(xs); ly = longint'(ys);
    if (lx == 0 || ly == 0) return 32'h0;
    num = p0*(lx-fx)*(ly-fy) + p1*fx*(ly-fy) + p2*(lx-fx)*fy + p3*fx*fy;
    return 32'(num / (lx*ly));
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && eng_start === 1'b1) start_cnt++;
  end

  // lerp2 stand-in: answers each start after 1..20 cycles, aborted by reset.
  initial begin
    logic [31:0] v;
    int lat;
    bit abort;
    eng_done = 1'b0; eng_error = 1'b0; eng_val = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && eng_start === 1'b1) begin
        call_no++;
        v = lerp_model(eng_p0, eng_p1, eng_p2, eng_p3, eng_x, eng_y, eng_X, eng_Y);
        lat = $urandom_range(1, 20);
        if (lat < min_lat) lat = min_lat;
        abort = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) abort = 1'b1;
        end
        if (!abort) begin
          eng_error = (call_no == err_call);
          eng_val   = eng_error ? 32'hDEAD : v;
          eng_done  = 1'b1;
          @(negedge clk);
          eng_done  = 1'b0;
          eng_error = 1'b0;
        end
      end
    end
  end

  task automatic wait_valid();
    int t = 0;
    while (out_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (out_valid !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL out_valid_timeout got out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic get_sample(output logic [31:0] v, output logic [15:0] xi, yi,
                            output logic last, err);
    wait_valid();
    v = out_val; xi = out_xi; yi = out_yi; last = out_last; err = out_error;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a0, a1, a2, a3, xs, ys);
    cmd_p0 = a0; cmd_p1 = a1; cmd_p2 = a2; cmd_p3 = a3; cmd_X = xs; cmd_Y = ys;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  logic [31:0] exp_v  [4] = '{32'h0, 32'h8000, 32'h10000, 32'h18000};
  logic [15:0] exp_xi [4] = '{16'd0, 16'd1, 16'd0, 16'd1};
  logic [15:0] exp_yi [4] = '{16'd0, 16'd0, 16'd1, 16'd1};
  logic        exp_l  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, eng_start, out_val, out_xi, out_yi, out_last, out_error,
         eng_p0, eng_x, eng_y, eng_X} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got valid=%b busy=%b start=%b val=%h want all 0",
               out_valid, busy, eng_start, out_val);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] v; logic [15:0] xi, yi; logic l, e;
    start_cnt = 0;
    send_cmd(32'h0, 32'h10000, 32'h20000, 32'h30000, 32'h20000, 32'h20000);
    n_cmp++;
    if (eng_start !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL t1_first_start got start=%b busy=%b want 1 1", eng_start, busy);
    end
    for (int i = 0; i < 4; i++) begin
      get_sample(v, xi, yi, l, e);
      n_cmp++;
      if (v !== exp_v[i] || xi !== exp_xi[i] || yi !== exp_yi[i] || l !== exp_l[i] || e !== 1'b0) begin
        n_bad++;
        $display("FAIL t1_sample%0d got val=%h (%0d,%0d) last=%b err=%b want val=%h (%0d,%0d) last=%b err=0",
                 i, v, xi, yi, l, e, exp_v[i], exp_xi[i], exp_yi[i], exp_l[i]);
      end
      if (i < 3) begin
        n_cmp++;
        if (eng_start !== 1'b1) begin
          n_bad++; $display("FAIL t1_next_start%0d got %b want 1", i, eng_start);
        end
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL t1_idle got busy=%b ready=%b want 0 1", busy, cmd_ready);
    end
    n_cmp++;
    if (start_cnt != 4) begin
      n_bad++; $display("FAIL t1_starts got %0d want 4", start_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v; logic [15:0] xi, yi; logic l, e;
    logic [64:0] snap;
    int s0;
    bit moved;
    send_cmd(32'h0, 32'h10000, 32'h20000, 32'h30000, 32'h20000, 32'h20000);
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      snap = {out_val, out_xi, out_yi, out_last};
      s0 = start_cnt;
      moved = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if ({out_val, out_xi, out_yi, out_last} !== snap || out_valid !== 1'b1) moved = 1'b1;
      end
      n_cmp++;
      if (moved || start_cnt != s0) begin
        n_bad++;
        $display("FAIL t2_hold%0d got moved=%b starts=%0d want moved=0 starts=%0d", i, moved, start_cnt, s0);
      end
      get_sample(v, xi, yi, l, e);
      n_cmp++;
      if (v !== exp_v[i] || xi !== exp_xi[i] || yi !== exp_yi[i] || l !== exp_l[i]) begin
        n_bad++;
        $display("FAIL t2_sample%0d got val=%h (%0d,%0d) last=%b want val=%h (%0d,%0d) last=%b",
                 i, v, xi, yi, l, exp_v[i], exp_xi[i], exp_yi[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] v; logic [15:0] xi, yi; logic l, e;
    start_cnt = 0; call_no = 0; err_call = 2;
    send_cmd(32'h0, 32'h10000, 32'h20000, 32'h30000, 32'h20000, 32'h20000);
    get_sample(v, xi, yi, l, e);
    n_cmp++;
    if (v !== 32'h0 || xi !== 16'd0 || yi !== 16'd0 || l !== 1'b0 || e !== 1'b0) begin
      n_bad++; $display("FAIL t3_first got val=%h (%0d,%0d) last=%b err=%b want 0 (0,0) 0 0", v, xi, yi, l, e);
    end
    get_sample(v, xi, yi, l, e);
    n_cmp++;
    if (v !== 32'hDEAD || xi !== 16'd1 || yi !== 16'd0 || l !== 1'b1 || e !== 1'b1) begin
      n_bad++; $display("FAIL t3_err got val=%h (%0d,%0d) last=%b err=%b want dead (1,0) 1 1", v, xi, yi, l, e);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || start_cnt != 2) begin
      n_bad++; $display("FAIL t3_end got ready=%b starts=%0d want 1 2", cmd_ready, start_cnt);
    end
    err_call = 0;
  endtask

  task automatic test_empty();
    logic [31:0] v; logic [15:0] xi, yi; logic l, e;
    start_cnt = 0;
    send_cmd(32'h10000, 32'h20000, 32'h30000, 32'h40000, 32'h8000, 32'h20000);
    get_sample(v, xi, yi, l, e);
    n_cmp++;
    if (v !== 32'h0 || xi !== 16'd0 || yi !== 16'd0 || l !== 1'b1 || e !== 1'b1) begin
      n_bad++; $display("FAIL t4_empty got val=%h (%0d,%0d) last=%b err=%b want 0 (0,0) 1 1", v, xi, yi, l, e);
    end
    n_cmp++;
    if (start_cnt != 0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL t4_nostart got starts=%0d ready=%b want 0 1", start_cnt, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v; logic [15:0] xi, yi; logic l, e;
    int t, stray;
    min_lat = 8; start_cnt = 0;
    send_cmd(32'h0, 32'h10000, 32'h20000, 32'h30000, 32'h20000, 32'h20000);
    get_sample(v, xi, yi, l, e);
    get_sample(v, xi, yi, l, e);
    t = 0;
    while (start_cnt < 3 && t < 100) begin @(negedge clk); t++; end
    n_cmp++;
    if (start_cnt != 3) begin
      n_bad++; $display("FAIL t5_third_start got %0d want 3", start_cnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, eng_start, out_val, out_xi, out_yi, out_last, out_error,
         eng_p0, eng_p1, eng_p2, eng_p3, eng_x, eng_y, eng_X, eng_Y} !== '0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL t5_reset_outputs got valid=%b busy=%b p1=%h X=%h ready=%b want 0s ready=1",
               out_valid, busy, eng_p1, eng_X, cmd_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || eng_start !== 1'b0 || cmd_ready !== 1'b1) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++; $display("FAIL t5_after_reset got %0d bad cycles want 0", stray);
    end
    min_lat = 1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v; logic [15:0] xi, yi; logic l, e;
    start_cnt = 0;
    cmd_p0 = 32'h0; cmd_p1 = 32'h10000; cmd_p2 = 32'h20000; cmd_p3 = 32'h30000;
    cmd_X = 32'h20000; cmd_Y = 32'h20000;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_p0 = 32'h50000; cmd_p1 = 32'h1234; cmd_p2 = 32'h5678; cmd_p3 = 32'h9abc;
    cmd_X = 32'h10000; cmd_Y = 32'h10000;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL t6_ready_busy got %b want 0", cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      get_sample(v, xi, yi, l, e);
      n_cmp++;
      if (v !== exp_v[i] || xi !== exp_xi[i] || yi !== exp_yi[i] || l !== exp_l[i]) begin
        n_bad++;
        $display("FAIL t6_sample%0d got val=%h (%0d,%0d) last=%b want val=%h (%0d,%0d) last=%b",
                 i, v, xi, yi, l, exp_v[i], exp_xi[i], exp_yi[i], exp_l[i]);
      end
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL t6_ready_after got %b want 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || eng_p0 !== 32'h50000) begin
      n_bad++; $display("FAIL t6_second_accept got busy=%b p0=%h want 1 50000", busy, eng_p0);
    end
    get_sample(v, xi, yi, l, e);
    n_cmp++;
    if (v !== 32'h50000 || xi !== 16'd0 || yi !== 16'd0 || l !== 1'b1 || e !== 1'b0) begin
      n_bad++; $display("FAIL t6_second got val=%h (%0d,%0d) last=%b err=%b want 50000 (0,0) 1 0", v, xi, yi, l, e);
    end
    n_cmp++;
    if (start_cnt != 5) begin
      n_bad++; $display("FAIL t6_starts got %0d want 5", start_cnt);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; out_ready = 1'b0;
    cmd_p0 = '0; cmd_p1 = '0; cmd_p2 = '0; cmd_p3 = '0; cmd_X = '0; cmd_Y = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_empty();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
